// File: rtl/renkon_mem_img_pp_pkg.sv
// Shared constants for the renkon ping-pong image memory.
//   DWIDTH  : data word width (signed samples)
//   IMGSIZE : address width, bank depth is 2**IMGSIZE
//   BANKS   : number of ping-pong banks
//   CNT_W   : width of the filled-bank counter (0..BANKS)
//   RD_LAT  : read latency in cycles
package renkon_mem_img_pp_pkg;
  localparam int DWIDTH  = 16;
  localparam int IMGSIZE = 12;
  localparam int BANKS   = 2;
  localparam int CNT_W   = 2;
  localparam int RD_LAT  = 1;

  localparam logic [CNT_W-1:0] FULL_CNT_MAX = CNT_W'(BANKS);
endpackage

// File: rtl/renkon_mem_img_bank.sv
// One image bank: synchronous write, registered read address.
// The read word is looked up combinationally from the registered address,
// so data appears the cycle after re is sampled.
//   clk    : clock
//   we     : write strobe
//   waddr  : write address
//   wdata  : write data
//   re     : read strobe, captures raddr
//   raddr  : read address
//   rdata  : word at the last captured read address
module renkon_mem_img_bank #(
  parameter int DWIDTH  = 16,
  parameter int IMGSIZE = 12
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IMGSIZE-1:0] waddr,
  input  logic [DWIDTH-1:0]  wdata,
  input  logic               re,
  input  logic [IMGSIZE-1:0] raddr,
  output logic [DWIDTH-1:0]  rdata
);
  localparam int WORDS = 2 ** IMGSIZE;

  logic [DWIDTH-1:0]  mem [WORDS];
  logic [IMGSIZE-1:0] raddr_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) raddr_q    <= raddr;
  end

  assign rdata = mem[raddr_q];
endmodule

// File: rtl/renkon_mem_img_pp.sv
// Ping-pong image memory between the DMA write side and the renkon read side.
// DMA fills the write bank while renkon reads the other; banks change hands on
// wr_done / rd_done pulses. Each bank tracks the fill length of its image.
//   clk, xrst           : clock, async active-low reset
//   wr_en/addr/data     : write into current write bank
//   wr_done             : write bank complete, hand to reader
//   wr_ready            : a bank is free for writing
//   rd_en/addr          : read from current read bank, 1-cycle latency
//   rd_done             : read bank consumed, release to writer
//   rd_ready            : a filled bank is available
//   rd_data / rd_valid  : read result, rd_data holds when no result
//   rd_len              : fill length of current read bank (0 when !rd_ready)
//   err                 : sticky, access or handshake while not ready
module renkon_mem_img_pp
  import renkon_mem_img_pp_pkg::*;
#(
  parameter int DWIDTH  = renkon_mem_img_pp_pkg::DWIDTH,
  parameter int IMGSIZE = renkon_mem_img_pp_pkg::IMGSIZE
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               wr_en,
  input  logic [IMGSIZE-1:0] wr_addr,
  input  logic [DWIDTH-1:0]  wr_data,
  input  logic               wr_done,
  output logic               wr_ready,
  input  logic               rd_en,
  input  logic [IMGSIZE-1:0] rd_addr,
  input  logic               rd_done,
  output logic               rd_ready,
  output logic [DWIDTH-1:0]  rd_data,
  output logic               rd_valid,
  output logic [IMGSIZE:0]   rd_len,
  output logic               err
);
  logic                           wr_sel, rd_sel, rsel_q;
  logic [CNT_W-1:0]               full_cnt;
  logic [BANKS-1:0][IMGSIZE:0]    len_q;
  logic [BANKS-1:0][DWIDTH-1:0]   bank_rdata;
  logic [DWIDTH-1:0]              data_q, mux_data;
  logic [RD_LAT:0]                vld_pipe;
  logic                           wr_acc, wd_acc, rd_acc, rdn_acc, bad;
  logic [IMGSIZE:0]               waddr_p1;

  assign wr_ready = (full_cnt < FULL_CNT_MAX);
  assign rd_ready = (full_cnt != '0);

  assign wr_acc  = wr_en   & wr_ready;
  assign wd_acc  = wr_done & wr_ready;
  assign rd_acc  = rd_en   & rd_ready;
  assign rdn_acc = rd_done & rd_ready;
  assign bad     = ((wr_en | wr_done) & ~wr_ready) | ((rd_en | rd_done) & ~rd_ready);

  assign waddr_p1 = {1'b0, wr_addr} + (IMGSIZE+1)'(1);

  // Bank array; only the bank under each pointer sees its strobes.
  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    renkon_mem_img_bank #(
      .DWIDTH  (DWIDTH),
      .IMGSIZE (IMGSIZE)
    ) u_bank (
      .clk   (clk),
      .we    (wr_acc & (wr_sel == 1'(g))),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (rd_acc & (rd_sel == 1'(g))),
      .raddr (rd_addr),
      .rdata (bank_rdata[g])
    );
  end

  // Pointers, occupancy and sticky error.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      rsel_q   <= 1'b0;
      full_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (wd_acc)  wr_sel <= ~wr_sel;
      if (rdn_acc) rd_sel <= ~rd_sel;
      // Bank used for the result is the one addressed at issue time, so a
      // read issued alongside rd_done still returns the old bank's data.
      if (rd_acc)  rsel_q <= rd_sel;
      case ({wd_acc, rdn_acc})
        2'b10:   full_cnt <= full_cnt + CNT_W'(1);
        2'b01:   full_cnt <= full_cnt - CNT_W'(1);
        default: full_cnt <= full_cnt;
      endcase
      if (bad) err <= 1'b1;
    end
  end

  // Fill lengths. A bank's length is cleared when the reader releases it,
  // which is the swap that returns it to the writer. The write bank and the
  // released bank never coincide, so the two updates cannot collide.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      len_q <= '0;
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        if (rdn_acc && rd_sel == b[0])
          len_q[b] <= '0;
        else if (wr_acc && wr_sel == b[0] && waddr_p1 > len_q[b])
          len_q[b] <= waddr_p1;
      end
    end
  end

  // Read valid shift register; stage 0 is the accepted strobe.
  assign vld_pipe[0] = rd_acc;
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) vld_pipe[RD_LAT:1] <= '0;
    else       vld_pipe[RD_LAT:1] <= vld_pipe[RD_LAT-1:0];
  end

  assign mux_data = bank_rdata[rsel_q];

  // Hold the last result so later writes to a released bank cannot leak out.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst)                 data_q <= '0;
    else if (vld_pipe[RD_LAT]) data_q <= mux_data;
  end

  assign rd_valid = vld_pipe[RD_LAT];
  assign rd_data  = vld_pipe[RD_LAT] ? mux_data : data_q;
  assign rd_len   = rd_ready ? len_q[rd_sel] : '0;
endmodule

// File: tb/tb_renkon_mem_img_pp.sv
module tb_renkon_mem_img_pp;
  logic        clk, xrst;
  logic        wr_en, wr_done, rd_en, rd_done;
  logic [11:0] wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        wr_ready, rd_ready, rd_valid, err;
  logic [15:0] rd_data;
  logic [12:0] rd_len;

  int checks = 0;
  int errors = 0;

  renkon_mem_img_pp dut (
    .clk      (clk),
    .xrst     (xrst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_done  (wr_done),
    .wr_ready (wr_ready),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_done  (rd_done),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_len   (rd_len),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [11:0] wa;
    logic [15:0] wd;
    logic        wdn;
    logic        re;
    logic [11:0] ra;
    logic        rdn;
    logic        e_wrr, e_rdr, e_vld;
    logic [15:0] e_data;
    logic [12:0] e_len;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic we, input logic [11:0] wa, input logic [15:0] wd,
                     input logic wdn, input logic re, input logic [11:0] ra, input logic rdn,
                     input logic e_wrr, input logic e_rdr, input logic e_vld,
                     input logic [15:0] e_data, input logic [12:0] e_len, input logic e_err);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.wdn = wdn;
    v.re = re; v.ra = ra; v.rdn = rdn;
    v.e_wrr = e_wrr; v.e_rdr = e_rdr; v.e_vld = e_vld;
    v.e_data = e_data; v.e_len = e_len; v.e_err = e_err;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic e_wrr, input logic e_rdr,
                       input logic e_vld, input logic [15:0] e_data,
                       input logic [12:0] e_len, input logic e_err);
    checks++;
    if ({wr_ready, rd_ready, rd_valid, rd_data, rd_len, err} !==
        {e_wrr, e_rdr, e_vld, e_data, e_len, e_err}) begin
      errors++;
      $display("FAIL %s: got wrr=%b rdr=%b vld=%b data=%h len=%0d err=%b, want wrr=%b rdr=%b vld=%b data=%h len=%0d err=%b",
               name, wr_ready, rd_ready, rd_valid, rd_data, rd_len, err,
               e_wrr, e_rdr, e_vld, e_data, e_len, e_err);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_done = 0;
    rd_en = 0; rd_addr = '0; rd_done = 0;
  endtask

  initial begin
    idle_inputs();
    xrst = 1'b0;

    // Image A in bank0: 100..109
    for (int i = 0; i < 10; i++)
      add(1, 12'(i), 16'(100 + i), 0, 0, 0, 0, 1, 0, 0, 16'h0, 13'd0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 16'h0, 13'd10, 0);
    // Read bank0 while filling bank1 (7FFF, -5 at addr 3)
    for (int i = 0; i < 10; i++)
      add(1, 12'(i), (i == 3) ? 16'hFFFB : 16'h7FFF, 0, 1, 12'(i), 0,
          1, 1, 1, 16'(100 + i), 13'd10, 0);
    // Simultaneous handover: count stays 1, both pointers swap
    add(0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 16'd109, 13'd10, 0);
    add(0, 0, 0, 0, 1, 12'd3, 0, 1, 1, 1, 16'hFFFB, 13'd10, 0);
    add(0, 0, 0, 0, 1, 12'd0, 0, 1, 1, 1, 16'h7FFF, 13'd10, 0);
    add(0, 0, 0, 0, 1, 12'd9, 0, 1, 1, 1, 16'h7FFF, 13'd10, 0);
    // Fill bank0 with two words, then both banks full
    add(1, 12'd0, 16'd1, 0, 0, 0, 0, 1, 1, 0, 16'h7FFF, 13'd10, 0);
    add(1, 12'd1, 16'd2, 0, 0, 0, 0, 1, 1, 0, 16'h7FFF, 13'd10, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h7FFF, 13'd10, 0);
    // Writes/handovers while full are dropped and flag err
    add(1, 12'd3, 16'd999, 0, 0, 0, 0, 0, 1, 0, 16'h7FFF, 13'd10, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h7FFF, 13'd10, 1);
    add(0, 0, 0, 0, 1, 12'd3, 0, 0, 1, 1, 16'hFFFB, 13'd10, 1);
    // Read alongside rd_done comes from the old bank; rd_len moves to bank0
    add(0, 0, 0, 0, 1, 12'd9, 1, 1, 1, 1, 16'h7FFF, 13'd2, 1);
    add(0, 0, 0, 0, 1, 12'd1, 0, 1, 1, 1, 16'd2, 13'd2, 1);
    add(0, 0, 0, 0, 1, 12'd0, 0, 1, 1, 1, 16'd1, 13'd2, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'd1, 13'd2, 1);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset", 1, 0, 0, 16'h0, 13'd0, 0);
    xrst = 1'b1;

    // Empty: reads and rd_done ignored, err set
    @(negedge clk);
    rd_en = 1; rd_addr = 12'd0;
    @(negedge clk);
    rd_en = 0;
    check("empty_rd", 1, 0, 0, 16'h0, 13'd0, 1);
    rd_done = 1;
    @(negedge clk);
    rd_done = 0;
    check("empty_done", 1, 0, 0, 16'h0, 13'd0, 1);
    @(negedge clk);
    check("empty_hold", 1, 0, 0, 16'h0, 13'd0, 1);

    // Reset clears sticky err
    xrst = 1'b0;
    #1;
    check("rst_err", 1, 0, 0, 16'h0, 13'd0, 0);
    @(negedge clk);
    xrst = 1'b1;

    // Table-driven main sequence
    for (int k = 0; k < vq.size(); k++) begin
      wr_en = vq[k].we; wr_addr = vq[k].wa; wr_data = vq[k].wd; wr_done = vq[k].wdn;
      rd_en = vq[k].re; rd_addr = vq[k].ra; rd_done = vq[k].rdn;
      @(negedge clk);
      check($sformatf("vec%0d", k), vq[k].e_wrr, vq[k].e_rdr, vq[k].e_vld,
            vq[k].e_data, vq[k].e_len, vq[k].e_err);
    end
    idle_inputs();

    // Async reset in the middle of a read burst from bank0
    rd_en = 1; rd_addr = 12'd0;
    @(negedge clk);
    check("burst_first", 1, 1, 1, 16'd1, 13'd2, 1);
    rd_addr = 12'd1;
    @(posedge clk);
    #2;
    check("burst_second", 1, 1, 1, 16'd2, 13'd2, 1);
    xrst = 1'b0;
    #1;
    check("async_rst", 1, 0, 0, 16'h0, 13'd0, 0);
    rd_en = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_held", 1, 0, 0, 16'h0, 13'd0, 0);
    xrst = 1'b1;
    @(negedge clk);
    check("after_release", 1, 0, 0, 16'h0, 13'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
